dcache_ctrl: RTL and testbench

DCACHE_CTRL -- requirements
Module: dcache_ctrl

---
 rtl/dcache_pkg.sv | 35 +++
 rtl/dcache_sram.sv | 76 +++++++
 rtl/dcache_ctrl.sv | 131 +++++++++++++
 tb/tb_dcache_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared geometry, state encoding and helpers for the direct-mapped
// write-back data cache controller (dcache_ctrl) and its storage (dcache_sram).
//   Geometry : 16 sets x 32-byte lines (8 x 32-bit words)
//   Address  : tag [31:9] | index [8:5] | word [4:2] | byte [1:0]
// ----------------------------------------------------------------------------
package dcache_pkg;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int SETS       = 16;
    localparam int LINE_BITS  = 256;
    localparam int WORDS      = LINE_BITS / WORD_W;   // 8 words per line
    localparam int OFF_W      = 5;                    // byte offset within line
    localparam int IDX_W      = 4;                    // set index width
    localparam int WSEL_W     = 3;                    // word select width
    localparam int TAG_W      = 23;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2,
        ST_FILL      = 2'd3
    } state_e;

    // Extract one 32-bit word from a cache line.
    function automatic logic [WORD_W-1:0] line_word(
        input logic [LINE_BITS-1:0] line,
        input logic [WSEL_W-1:0]    sel
    );
        return line[sel*WORD_W +: WORD_W];
    endfunction

endpackage

// File: rtl/dcache_sram.sv
// ----------------------------------------------------------------------------
// dcache_sram
// Tag / valid / dirty / data storage for the data cache.
// Asynchronous read of the set selected by idx_i; synchronous writes.
// Reset clears only the valid and dirty bits; tag and data are left as-is.
// Ports:
//   clk_i, rst_i       clock, asynchronous active-high reset
//   idx_i              set index used for both read and write
//   rd_valid_o/dirty_o state bits of the selected set
//   rd_tag_o           stored tag of the selected set
//   rd_line_o          stored line of the selected set
//   fill_en_i          write fill_tag_i/fill_line_i, set valid, clear dirty
//   store_en_i         write store_data_i into word store_word_i, set dirty
// ----------------------------------------------------------------------------
module dcache_sram
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IDX_W-1:0]     idx_i,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 fill_en_i,
    input  logic [TAG_W-1:0]     fill_tag_i,
    input  logic [LINE_BITS-1:0] fill_line_i,
    input  logic                 store_en_i,
    input  logic [WSEL_W-1:0]    store_word_i,
    input  logic [WORD_W-1:0]    store_data_i
);

    logic [SETS-1:0]      r_valid;
    logic [SETS-1:0]      r_dirty;
    logic [TAG_W-1:0]     r_tag_mem  [SETS];
    logic [LINE_BITS-1:0] r_line_mem [SETS];
    logic [LINE_BITS-1:0] w_store_line;

    assign rd_valid_o = r_valid[idx_i];
    assign rd_dirty_o = r_dirty[idx_i];
    assign rd_tag_o   = r_tag_mem[idx_i];
    assign rd_line_o  = r_line_mem[idx_i];

    // Merge the store word into the current line contents.
    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_merge
            assign w_store_line[gi*WORD_W +: WORD_W] =
                (store_word_i == WSEL_W'(gi)) ? store_data_i
                                              : rd_line_o[gi*WORD_W +: WORD_W];
        end
    endgenerate

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else if (fill_en_i) begin
            r_valid[idx_i] <= 1'b1;
            r_dirty[idx_i] <= 1'b0;
        end else if (store_en_i) begin
            r_dirty[idx_i] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; validity is governed by r_valid.
    always_ff @(posedge clk_i) begin
        if (fill_en_i) begin
            r_tag_mem[idx_i]  <= fill_tag_i;
            r_line_mem[idx_i] <= fill_line_i;
        end else if (store_en_i) begin
            r_line_mem[idx_i] <= w_store_line;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// ----------------------------------------------------------------------------
// dcache_ctrl
// Direct-mapped, write-back, write-allocate data cache controller for the
// MEM stage. Hits complete with zero added latency; misses stall the pipeline
// while a dirty victim is written back and the requested line is fetched.
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   cpu_req_i/wr_i/addr_i/data_i  pipeline load/store request (held while stalled)
//   cpu_data_o                 load data (valid when req && !stall)
//   cpu_stall_o                pipeline stall
//   mem_req_o/wr_o/addr_o/data_o  line-granular off-chip request
//   mem_data_i, mem_ack_i      fetched line and single-cycle completion pulse
// ----------------------------------------------------------------------------
module dcache_ctrl
    import dcache_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 cpu_req_i,
    input  logic                 cpu_wr_i,
    input  logic [ADDR_W-1:0]    cpu_addr_i,
    input  logic [WORD_W-1:0]    cpu_data_i,
    output logic [WORD_W-1:0]    cpu_data_o,
    output logic                 cpu_stall_o,
    output logic                 mem_req_o,
    output logic                 mem_wr_o,
    output logic [ADDR_W-1:0]    mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i
);

    state_e               r_state;
    state_e               w_state_next;

    logic [IDX_W-1:0]     w_idx;
    logic [TAG_W-1:0]     w_tag;
    logic [WSEL_W-1:0]    w_word;
    logic                 w_valid;
    logic                 w_dirty;
    logic [TAG_W-1:0]     w_tag_rd;
    logic [LINE_BITS-1:0] w_line_rd;
    logic                 w_hit;
    logic                 w_fill_en;
    logic                 w_store_en;

    assign w_idx  = cpu_addr_i[OFF_W +: IDX_W];
    assign w_tag  = cpu_addr_i[ADDR_W-1 -: TAG_W];
    assign w_word = cpu_addr_i[2 +: WSEL_W];

    dcache_sram u_sram (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .idx_i        (w_idx),
        .rd_valid_o   (w_valid),
        .rd_dirty_o   (w_dirty),
        .rd_tag_o     (w_tag_rd),
        .rd_line_o    (w_line_rd),
        .fill_en_i    (w_fill_en),
        .fill_tag_i   (w_tag),
        .fill_line_i  (mem_data_i),
        .store_en_i   (w_store_en),
        .store_word_i (w_word),
        .store_data_i (cpu_data_i)
    );

    assign w_hit      = w_valid && (w_tag_rd == w_tag);
    assign cpu_data_o = line_word(w_line_rd, w_word);
    // While in WRITEBACK the selected set is still the victim, because the
    // pipeline holds cpu_addr_i stable and the array read is asynchronous.
    assign mem_data_o = w_line_rd;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        cpu_stall_o  = 1'b0;
        mem_req_o    = 1'b0;
        mem_wr_o     = 1'b0;
        mem_addr_o   = '0;
        w_fill_en    = 1'b0;
        w_store_en   = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (cpu_req_i) begin
                    if (w_hit) begin
                        w_store_en = cpu_wr_i;
                    end else begin
                        cpu_stall_o  = 1'b1;
                        w_state_next = (w_valid && w_dirty) ? ST_WRITEBACK
                                                            : ST_ALLOCATE;
                    end
                end
            end
            ST_WRITEBACK: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_wr_o    = 1'b1;
                mem_addr_o  = {w_tag_rd, w_idx, {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_state_next = ST_ALLOCATE;
                end
            end
            ST_ALLOCATE: begin
                cpu_stall_o = 1'b1;
                mem_req_o   = 1'b1;
                mem_addr_o  = {cpu_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                if (mem_ack_i) begin
                    w_fill_en    = 1'b1;
                    w_state_next = ST_FILL;
                end
            end
            ST_FILL: begin
                // One bubble so the retried access sees the new line in IDLE.
                cpu_stall_o  = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dcache_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dcache_ctrl
// Directed bench for dcache_ctrl: hand-driven memory responses, a table of
// hit vectors and hand-written miss / writeback / reset / spurious-ack
// sequences.
// ----------------------------------------------------------------------------
module tb_dcache_ctrl;
    import dcache_pkg::*;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         cpu_req_i;
    logic         cpu_wr_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_req_o;
    logic         mem_wr_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    dcache_ctrl dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .cpu_req_i   (cpu_req_i),
        .cpu_wr_i    (cpu_wr_i),
        .cpu_addr_i  (cpu_addr_i),
        .cpu_data_i  (cpu_data_i),
        .cpu_data_o  (cpu_data_o),
        .cpu_stall_o (cpu_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_wr_o    (mem_wr_o),
        .mem_addr_o  (mem_addr_o),
        .mem_data_o  (mem_data_o),
        .mem_data_i  (mem_data_i),
        .mem_ack_i   (mem_ack_i)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        req;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_stall;
        logic        chk_data;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [255:0] make_line(input logic [31:0] base,
                                               input int sp_idx,
                                               input logic [31:0] sp_val);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = (w == sp_idx) ? sp_val : (base + 32'(w));
        end
        return l;
    endfunction

    function automatic logic [31:0] word_of(input logic [255:0] l, input int w);
        return l[w*32 +: 32];
    endfunction

    // Acknowledge the current memory request with the given line.
    task automatic ack_with(input logic [255:0] line);
        mem_data_i = line;
        mem_ack_i  = 1'b1;
        step();
        mem_ack_i  = 1'b0;
    endtask

    logic [255:0] line1;
    logic [255:0] line2;

    initial begin
        line1 = make_line(32'hA000_0000, 1, 32'hDEAD_BEEF);
        line2 = make_line(32'hB000_0000, -1, 32'h0);

        //            req   wr    addr          wdata         stall chk   exp_data
        vecs[0] = '{1'b1, 1'b1, 32'h0000_0208, 32'h1234_5678, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b1, 1'b0, 32'h0000_0208, 32'h0,         1'b0, 1'b1, 32'h1234_5678};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,         1'b0, 1'b1, 32'hDEAD_BEEF};
        vecs[3] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,         1'b0, 1'b1, 32'hA000_0000};
        vecs[4] = '{1'b1, 1'b1, 32'h0000_021C, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 32'h0000_021F, 32'h0,         1'b0, 1'b1, 32'hCAFE_F00D};
        vecs[6] = '{1'b0, 1'b1, 32'h0000_0408, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0};
        vecs[7] = '{1'b1, 1'b0, 32'h0000_0214, 32'h0,         1'b0, 1'b1, 32'hA000_0005};

        // ---------------- reset ----------------
        rst_i      = 1'b1;
        cpu_req_i  = 1'b0;
        cpu_wr_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        mem_data_i = '0;
        mem_ack_i  = 1'b0;
        step();
        step();
        chk("reset_stall", 32'(cpu_stall_o), 32'd0);
        chk("reset_mem_req", 32'(mem_req_o), 32'd0);
        chk("reset_mem_wr", 32'(mem_wr_o), 32'd0);
        rst_i = 1'b0;
        step();

        // ---------------- cold load miss ----------------
        cpu_req_i  = 1'b1;
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 32'h0000_0204;
        #1;
        chk("cold_stall_same_cycle", 32'(cpu_stall_o), 32'd1);
        chk("cold_no_req_in_idle", 32'(mem_req_o), 32'd0);
        step();
        chk("cold_alloc_req", 32'(mem_req_o), 32'd1);
        chk("cold_alloc_wr", 32'(mem_wr_o), 32'd0);
        chk("cold_alloc_addr", mem_addr_o, 32'h0000_0200);
        chk("cold_alloc_stall", 32'(cpu_stall_o), 32'd1);
        step();
        ack_with(line1);
        chk("cold_fill_req", 32'(mem_req_o), 32'd0);
        chk("cold_fill_stall", 32'(cpu_stall_o), 32'd1);
        step();
        chk("cold_hit_stall", 32'(cpu_stall_o), 32'd0);
        chk("cold_hit_data", cpu_data_o, 32'hDEAD_BEEF);
        $display("txn cold load 0x00000204 data=0x%08h stall=%0b", cpu_data_o, cpu_stall_o);

        // ---------------- table of hits ----------------
        for (int i = 0; i < 8; i++) begin
            cpu_req_i  = vecs[i].req;
            cpu_wr_i   = vecs[i].wr;
            cpu_addr_i = vecs[i].addr;
            cpu_data_i = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_stall", i), 32'(cpu_stall_o), 32'(vecs[i].exp_stall));
            chk($sformatf("vec%0d_mem_req", i), 32'(mem_req_o), 32'd0);
            if (vecs[i].chk_data)
                chk($sformatf("vec%0d_data", i), cpu_data_o, vecs[i].exp_data);
            $display("txn vec%0d req=%0b wr=%0b addr=0x%08h wdata=0x%08h rdata=0x%08h stall=%0b",
                     i, cpu_req_i, cpu_wr_i, cpu_addr_i, cpu_data_i, cpu_data_o, cpu_stall_o);
            step();
        end

        // ---------------- dirty victim: writeback then allocate ----------------
        cpu_req_i  = 1'b1;
        cpu_wr_i   = 1'b0;
        cpu_addr_i = 32'h0000_0408;
        cpu_data_i = '0;
        #1;
        chk("wb_miss_stall", 32'(cpu_stall_o), 32'd1);
        step();
        chk("wb_req", 32'(mem_req_o), 32'd1);
        chk("wb_wr", 32'(mem_wr_o), 32'd1);
        chk("wb_addr", mem_addr_o, 32'h0000_0200);
        chk("wb_word2", word_of(mem_data_o, 2), 32'h1234_5678);
        chk("wb_word1", word_of(mem_data_o, 1), 32'hDEAD_BEEF);
        chk("wb_word7", word_of(mem_data_o, 7), 32'hCAFE_F00D);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("wb_hold%0d_req", c), 32'(mem_req_o), 32'd1);
            chk($sformatf("wb_hold%0d_stall", c), 32'(cpu_stall_o), 32'd1);
            chk($sformatf("wb_hold%0d_addr", c), mem_addr_o, 32'h0000_0200);
            chk($sformatf("wb_hold%0d_wr", c), 32'(mem_wr_o), 32'd1);
        end
        ack_with('0);
        chk("alloc2_req", 32'(mem_req_o), 32'd1);
        chk("alloc2_wr", 32'(mem_wr_o), 32'd0);
        chk("alloc2_addr", mem_addr_o, 32'h0000_0400);
        ack_with(line2);
        chk("fill2_req", 32'(mem_req_o), 32'd0);
        step();
        chk("hit2_stall", 32'(cpu_stall_o), 32'd0);
        chk("hit2_data", cpu_data_o, 32'hB000_0002);
        $display("txn load 0x00000408 after writeback data=0x%08h", cpu_data_o);

        // ---------------- spurious ack in IDLE ----------------
        cpu_req_i = 1'b0;
        ack_with({256{1'b1}});
        chk("spur_mem_req", 32'(mem_req_o), 32'd0);
        chk("spur_stall", 32'(cpu_stall_o), 32'd0);
        cpu_req_i = 1'b1;
        #1;
        chk("spur_hit_stall", 32'(cpu_stall_o), 32'd0);
        chk("spur_hit_data", cpu_data_o, 32'hB000_0002);
        $display("txn spurious ack, reload 0x00000408 data=0x%08h", cpu_data_o);
        step();

        // ---------------- reset during ALLOCATE ----------------
        cpu_addr_i = 32'h0000_0604;
        #1;
        chk("rst_miss_stall", 32'(cpu_stall_o), 32'd1);
        step();
        chk("rst_alloc_req", 32'(mem_req_o), 32'd1);
        chk("rst_alloc_wr", 32'(mem_wr_o), 32'd0);
        chk("rst_alloc_addr", mem_addr_o, 32'h0000_0600);
        step();
        rst_i = 1'b1;
        #1;
        chk("rst_async_req", 32'(mem_req_o), 32'd0);
        chk("rst_async_wr", 32'(mem_wr_o), 32'd0);
        step();
        rst_i = 1'b0;
        #1;
        chk("post_rst_miss_stall", 32'(cpu_stall_o), 32'd1);
        chk("post_rst_idle_req", 32'(mem_req_o), 32'd0);
        cpu_addr_i = 32'h0000_0408;
        #1;
        chk("post_rst_old_line_miss", 32'(cpu_stall_o), 32'd1);
        $display("txn reset during allocate, 0x00000408 stall=%0b", cpu_stall_o);
        cpu_req_i = 1'b0;
        step();
        chk("end_idle_req", 32'(mem_req_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
